// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - register map, CTRL bit indices and breathe state encoding for led_pwm
package led_pwm_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PRESCALE = 8'h01;
    localparam logic [7:0] ADDR_DUTY_R   = 8'h02;
    localparam logic [7:0] ADDR_DUTY_G   = 8'h03;
    localparam logic [7:0] ADDR_DUTY_B   = 8'h04;
    localparam logic [7:0] ADDR_STATUS   = 8'h05;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_BREATHE_BIT = 1;

    typedef enum logic [1:0] {
        BR_UP      = 2'd0,
        BR_HOLD_HI = 2'd1,
        BR_DOWN    = 2'd2,
        BR_HOLD_LO = 2'd3
    } breathe_state_t;

    // Duty arrays are indexed by pwm_out bit: R=2, G=1, B=0.
    function automatic logic [1:0] duty_sel(input logic [7:0] addr);
        return 2'(ADDR_DUTY_B - addr);
    endfunction

endpackage

// File: rtl/led_pwm_if.sv
// rtl/led_pwm_if.sv - register access port of led_pwm
interface led_pwm_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, we, address, write_data, input read_data, ready);
    modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one colour channel: duty compare and registered drive
module led_pwm_channel #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              led,
    input  logic [DUTY_W-1:0] count,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    // Disabled: pass the on/off request straight through, one cycle late.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm <= 1'b0;
        end else begin
            pwm <= led && (!enable || (count < duty));
        end
    end

endmodule

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - RGB LED PWM with prescaler and register bank; breathing built with LED_PWM_BREATHE_EN
module led_pwm
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int DUTY_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] led_in,
    led_pwm_if.slave   bus,
    output logic [2:0] pwm_out
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    logic                  enable;
    logic                  breathe;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic [DUTY_W-1:0]     pwm_cnt;
    logic [DUTY_W-1:0]     shadow_duty [3];
    logic [DUTY_W-1:0]     active_duty [3];
    logic [DUTY_W-1:0]     eff_duty    [3];
    logic [31:0]           status;
    logic                  wr_en;
    logic                  ctrl_wr;
    logic                  presc_wr;
    logic                  tick;
    logic                  boundary;
    logic                  unused_wdata;

    assign wr_en        = bus.cs && bus.we;
    assign ctrl_wr      = wr_en && (bus.address == ADDR_CTRL);
    assign presc_wr     = wr_en && (bus.address == ADDR_PRESCALE);
    assign tick         = enable && (presc_cnt == prescale);
    assign boundary     = tick && (pwm_cnt == DUTY_MAX);
    assign unused_wdata = ^bus.write_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            prescale <= '0;
            for (int i = 0; i < 3; i++) shadow_duty[i] <= DUTY_MAX;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_CTRL:     enable   <= bus.write_data[CTRL_ENABLE_BIT];
                ADDR_PRESCALE: prescale <= bus.write_data[PRESCALE_W-1:0];
                ADDR_DUTY_R, ADDR_DUTY_G, ADDR_DUTY_B:
                    shadow_duty[duty_sel(bus.address)] <= bus.write_data[DUTY_W-1:0];
                default: ;
            endcase
        end
    end

    // Shadow values sampled before this edge's write, so a coincident write waits a period.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) active_duty[i] <= DUTY_MAX;
        end else if (boundary) begin
            for (int i = 0; i < 3; i++) active_duty[i] <= shadow_duty[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= (presc_wr || tick) ? '0 : presc_cnt + PRESCALE_W'(1);
            if (tick) pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

`ifdef LED_PWM_BREATHE_EN
    localparam int PROD_W = 2 * DUTY_W;
    typedef logic [PROD_W-1:0] prod_t;

    breathe_state_t    state;
    breathe_state_t    state_next;
    logic [DUTY_W-1:0] level;
    logic [DUTY_W-1:0] level_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            breathe <= 1'b0;
        end else if (ctrl_wr) begin
            breathe <= bus.write_data[CTRL_BREATHE_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state <= BR_UP;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    // Saturating ramp; the turn-around is taken on the same boundary the extreme is reached.
    always_comb begin
        state_next = state;
        level_next = level;
        if (breathe && boundary) begin
            case (state)
                BR_UP: begin
                    if (level != DUTY_MAX) level_next = level + DUTY_W'(1);
                    if (level >= DUTY_MAX - DUTY_W'(1)) state_next = BR_HOLD_HI;
                end
                BR_HOLD_HI: state_next = BR_DOWN;
                BR_DOWN: begin
                    if (level != '0) level_next = level - DUTY_W'(1);
                    if (level <= DUTY_W'(1)) state_next = BR_HOLD_LO;
                end
                default: state_next = BR_UP;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eff_duty[i] = active_duty[i];
            if (breathe) eff_duty[i] = DUTY_W'((prod_t'(active_duty[i]) * prod_t'(level)) >> DUTY_W);
        end
    end

    assign status = 32'({state, level});
`else
    assign breathe = 1'b0;
    assign status  = '0;

    always_comb begin
        for (int i = 0; i < 3; i++) eff_duty[i] = active_duty[i];
    end
`endif

    assign bus.ready = bus.cs;

    always_comb begin
        bus.read_data = '0;
        if (bus.cs && !bus.we) begin
            case (bus.address)
                ADDR_CTRL:     bus.read_data = {30'd0, breathe, enable};
                ADDR_PRESCALE: bus.read_data = 32'(prescale);
                ADDR_DUTY_R, ADDR_DUTY_G, ADDR_DUTY_B:
                    bus.read_data = 32'(shadow_duty[duty_sel(bus.address)]);
                ADDR_STATUS:   bus.read_data = status;
                default:       bus.read_data = '0;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        led_pwm_channel #(.DUTY_W(DUTY_W)) u_chan (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .led    (led_in[i]),
            .count  (pwm_cnt),
            .duty   (eff_duty[i]),
            .pwm    (pwm_out[i])
        );
    end

endmodule
